// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter: loads a word on valid/ready and sends it one bit per clock.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits of every frame.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_shiftQ;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] w_shifted;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_lastData;
    logic             w_lastBit;
    logic             w_accept;
    logic             w_outBit;

    // The bit being sent always sits at the output end; shifting moves the next one there.
    assign w_shifted  = MSB_FIRST ? {r_shiftQ[WIDTH-2:0], 1'b0} : {1'b0, r_shiftQ[WIDTH-1:1]};
    assign w_outBit   = MSB_FIRST ? r_shiftQ[WIDTH-1] : r_shiftQ[0];
    assign w_lastData = (r_state == SHIFT) && (r_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
    logic r_parQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parQ <= 1'b0;
        end else if (w_accept) begin
            r_parQ <= ^data_i;
        end
    end

    assign w_lastBit = (r_state == PARITY);
`else
    assign w_lastBit = w_lastData;
`endif

    assign ready_o  = (r_state == IDLE) || w_lastBit;
    assign busy_o   = (r_state != IDLE);
    assign done_o   = w_lastBit;
    assign w_accept = valid_i && ready_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shiftQ <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_shiftQ <= w_shiftNext;
            r_cnt    <= w_cntNext;
        end
    end

    // An accept on the last-bit cycle overrides the return to IDLE, giving gap-free frames.
    always_comb begin
        w_stateNext = r_state;
        w_shiftNext = r_shiftQ;
        w_cntNext   = r_cnt;
        x_o         = 1'b0;
        case (r_state)
            SHIFT: begin
                x_o         = w_outBit;
                w_shiftNext = w_shifted;
                if (w_lastData) begin
                    w_cntNext = '0;
`ifdef PISO_PARITY_EN
                    w_stateNext = PARITY;
`else
                    w_stateNext = IDLE;
`endif
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                x_o         = r_parQ;
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
`endif
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
        if (w_accept) begin
            w_stateNext = SHIFT;
            w_shiftNext = data_i;
            w_cntNext   = '0;
        end
    end

endmodule
